// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit datapath: widths, field types and the
// execute-register payload, plus the immediate sign-extension helper.
package cpu16_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_N   = 8;
  localparam int REG_AW  = 3;
  localparam int IMM_W   = 8;
  localparam int ALUOP_W = 4;
  localparam int SHAMT_W = 4;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [REG_AW-1:0]  reg_addr_t;
  typedef logic [IMM_W-1:0]   imm_t;
  typedef logic [ALUOP_W-1:0] aluop_t;
  typedef logic [SHAMT_W-1:0] shamt_t;
  typedef logic [REG_N-1:0]   reg_mask_t;

  // Everything the execute register captures at issue.
  typedef struct packed {
    word_t     a;
    word_t     b;
    aluop_t    aluop;
    shamt_t    shamt;
    reg_addr_t rd;
    logic      wr_en;
  } ex_payload_t;

  // Immediate to operand width, replicating the immediate's sign bit.
  function automatic word_t sext_imm(input imm_t imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/operand_issue_stage_if.sv
// Bundle of the decode-side request, execute-side result and writeback port
// of the operand/issue stage. The stage uses the slave view; whatever feeds
// decode, consumes execute and returns writebacks uses the master view.
interface operand_issue_stage_if;
  import cpu16_pkg::*;

  logic      in_valid;
  logic      in_ready;
  reg_addr_t in_rs;
  reg_addr_t in_rt;
  reg_addr_t in_rd;
  imm_t      in_imm;
  logic      in_use_imm;
  logic      in_wr_en;
  aluop_t    in_aluop;
  shamt_t    in_shamt;

  logic      ex_valid;
  logic      ex_ready;
  word_t     ex_a;
  word_t     ex_b;
  aluop_t    ex_aluop;
  shamt_t    ex_shamt;
  reg_addr_t ex_rd;
  logic      ex_wr_en;

  logic      wb_en;
  reg_addr_t wb_addr;
  word_t     wb_data;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_wr_en,
           in_aluop, in_shamt, ex_ready, wb_en, wb_addr, wb_data,
    input  in_ready, ex_valid, ex_a, ex_b, ex_aluop, ex_shamt, ex_rd, ex_wr_en
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_wr_en,
           in_aluop, in_shamt, ex_ready, wb_en, wb_addr, wb_data,
    output in_ready, ex_valid, ex_a, ex_b, ex_aluop, ex_shamt, ex_rd, ex_wr_en
  );

endinterface

// File: rtl/reg_file_8x16.sv
// 8x16 register file: two combinational read ports with write-through bypass,
// one synchronous write port, R0 hard-wired to zero.
module reg_file_8x16
  import cpu16_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t rd_addr_a,
  output word_t     rd_data_a,
  input  reg_addr_t rd_addr_b,
  output word_t     rd_data_b,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  word_t     wr_data
);

  word_t regs_r [REG_N];
  logic  wr_hit_s;

  // R0 is never a write target; it stays at its reset value of zero.
  assign wr_hit_s = wr_en & (wr_addr != {REG_AW{1'b0}});

  // One read port: zero for R0, bypassed write data on an address match,
  // otherwise the stored value.
  function automatic word_t read_port(input reg_addr_t addr);
    word_t val;
    if (addr == {REG_AW{1'b0}}) begin
      val = {DATA_W{1'b0}};
    end else if (wr_hit_s && (wr_addr == addr)) begin
      val = wr_data;
    end else begin
      val = regs_r[addr];
    end
    return val;
  endfunction

  // Storage update: clear everything on reset, otherwise apply the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_hit_s) begin
      regs_r[wr_addr] <= wr_data;
    end else begin
      regs_r[wr_addr] <= regs_r[wr_addr];
    end
  end

  // Both read ports, resolved combinationally.
  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

endmodule

// File: rtl/operand_issue_stage.sv
// Operand fetch and issue: register file, per-register busy scoreboard,
// hazard detection and the execute pipeline register feeding the ALU.
module operand_issue_stage
  import cpu16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  operand_issue_stage_if.slave bus
);

  word_t       rd_a_s;
  word_t       rd_b_s;
  reg_mask_t   busy_r;
  reg_mask_t   busy_nxt_s;
  reg_mask_t   clr_mask_s;
  reg_mask_t   set_mask_s;
  reg_mask_t   busy_eff_s;
  logic        hazard_s;
  logic        in_ready_s;
  logic        issue_s;
  logic        ex_valid_r;
  ex_payload_t ex_r;
  ex_payload_t payload_s;

  reg_file_8x16 u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (bus.in_rs),
    .rd_data_a (rd_a_s),
    .rd_addr_b (bus.in_rt),
    .rd_data_b (rd_b_s),
    .wr_en     (bus.wb_en),
    .wr_addr   (bus.wb_addr),
    .wr_data   (bus.wb_data)
  );

  // Busy bits being released by this cycle's writeback; the bypass already
  // supplies their data, so they neither stall nor stay busy.
  always_comb begin
    clr_mask_s = {REG_N{1'b0}};
    if (bus.wb_en) begin
      clr_mask_s[bus.wb_addr] = 1'b1;
    end else begin
      clr_mask_s = {REG_N{1'b0}};
    end
  end

  // Hazard check (RAW on A, RAW on B when not immediate, WAW on rd) and the
  // resulting ready. in_valid deliberately takes no part in in_ready.
  always_comb begin
    busy_eff_s = busy_r & ~clr_mask_s;
    hazard_s   = busy_eff_s[bus.in_rs]
               | (~bus.in_use_imm & busy_eff_s[bus.in_rt])
               | (bus.in_wr_en & busy_eff_s[bus.in_rd]);
    in_ready_s = ~hazard_s & (~ex_valid_r | bus.ex_ready);
    issue_s    = bus.in_valid & in_ready_s;
  end

  // Busy bit claimed by the issuing instruction; R0 is never claimed.
  always_comb begin
    set_mask_s = {REG_N{1'b0}};
    if (issue_s && bus.in_wr_en && (bus.in_rd != {REG_AW{1'b0}})) begin
      set_mask_s[bus.in_rd] = 1'b1;
    end else begin
      set_mask_s = {REG_N{1'b0}};
    end
    // A set and a clear on the same register in one cycle leave it busy.
    busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {REG_N{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Operand selection for the instruction being issued.
  always_comb begin
    payload_s.a     = rd_a_s;
    payload_s.b     = bus.in_use_imm ? sext_imm(bus.in_imm) : rd_b_s;
    payload_s.aluop = bus.in_aluop;
    payload_s.shamt = bus.in_shamt;
    payload_s.rd    = bus.in_rd;
    payload_s.wr_en = bus.in_wr_en;
  end

  // Execute register: load on issue, drop valid when consumed without a
  // replacement, otherwise hold everything steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r <= 1'b0;
      ex_r       <= '{a: {DATA_W{1'b0}}, b: {DATA_W{1'b0}},
                      aluop: {ALUOP_W{1'b0}}, shamt: {SHAMT_W{1'b0}},
                      rd: {REG_AW{1'b0}}, wr_en: 1'b0};
    end else if (issue_s) begin
      ex_valid_r <= 1'b1;
      ex_r       <= payload_s;
    end else if (bus.ex_ready) begin
      ex_valid_r <= 1'b0;
      ex_r       <= ex_r;
    end else begin
      ex_valid_r <= ex_valid_r;
      ex_r       <= ex_r;
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.ex_valid = ex_valid_r;
  assign bus.ex_a     = ex_r.a;
  assign bus.ex_b     = ex_r.b;
  assign bus.ex_aluop = ex_r.aluop;
  assign bus.ex_shamt = ex_r.shamt;
  assign bus.ex_rd    = ex_r.rd;
  assign bus.ex_wr_en = ex_r.wr_en;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Table-driven bench for operand_issue_stage with a scoreboard queue of
// expected execute-register contents.
module tb_operand_issue_stage;
  import cpu16_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_issue_stage_if bus ();

  operand_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       v;
    logic [2:0] rs, rt, rd;
    logic [7:0] imm;
    logic       ui, we;
    logic [3:0] op, sh;
    logic       exr, wbe;
    logic [2:0] wba;
    logic [15:0] wbd;
    logic       rdy;
    logic [15:0] a, b;
  } vec_t;

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  op, sh;
    logic [2:0]  rd;
    logic        we;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic vec_t mk(logic v, logic [2:0] rs, logic [2:0] rt, logic [2:0] rd,
                              logic [7:0] imm, logic ui, logic we, logic [3:0] op,
                              logic [3:0] sh, logic exr, logic wbe, logic [2:0] wba,
                              logic [15:0] wbd, logic rdy, logic [15:0] a, logic [15:0] b);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.rd = rd; r.imm = imm; r.ui = ui; r.we = we;
    r.op = op; r.sh = sh; r.exr = exr; r.wbe = wbe; r.wba = wba; r.wbd = wbd;
    r.rdy = rdy; r.a = a; r.b = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = v.v;   bus.in_rs = v.rs;   bus.in_rt = v.rt;   bus.in_rd = v.rd;
    bus.in_imm = v.imm;   bus.in_use_imm = v.ui; bus.in_wr_en = v.we;
    bus.in_aluop = v.op;  bus.in_shamt = v.sh;
    bus.ex_ready = v.exr; bus.wb_en = v.wbe;  bus.wb_addr = v.wba; bus.wb_data = v.wbd;
  endtask

  // One cycle: drive after the rising edge, check on the falling edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, v.rdy});
    chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, sb.size() != 0});
    if (bus.ex_valid && sb.size() > 0) begin
      e = sb[0];
      chk("ex_a", {16'd0, bus.ex_a}, {16'd0, e.a});
      chk("ex_b", {16'd0, bus.ex_b}, {16'd0, e.b});
      chk("ex_aluop", {28'd0, bus.ex_aluop}, {28'd0, e.op});
      chk("ex_shamt", {28'd0, bus.ex_shamt}, {28'd0, e.sh});
      chk("ex_rd", {29'd0, bus.ex_rd}, {29'd0, e.rd});
      chk("ex_wr_en", {31'd0, bus.ex_wr_en}, {31'd0, e.we});
      if (bus.ex_ready) void'(sb.pop_front());
    end
    if (v.v && v.rdy) begin
      e.a = v.a; e.b = v.b; e.op = v.op; e.sh = v.sh; e.rd = v.rd; e.we = v.we;
      sb.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,8'h00,0,0,4'h0,4'h0,1,0,0,16'h0000,1,16'h0000,16'h0000);
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst ex_a", {16'd0, bus.ex_a}, 32'd0);
    chk("rst ex_b", {16'd0, bus.ex_b}, 32'd0);
    chk("rst ex_aluop", {28'd0, bus.ex_aluop}, 32'd0);
    chk("rst ex_shamt", {28'd0, bus.ex_shamt}, 32'd0);
    chk("rst ex_rd", {29'd0, bus.ex_rd}, 32'd0);
    chk("rst ex_wr_en", {31'd0, bus.ex_wr_en}, 32'd0);

    //            v rs rt rd imm   ui we op    sh    exr wbe wba wbd       rdy a         b
    vecs.push_back(mk(1,3,0,0,8'h00,0,0,4'h1,4'h0,1,0,0,16'h0000,1,16'h0000,16'h0000)); // R3 reads 0
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,4'h0,4'h0,1,1,2,16'h1234,1,16'h0000,16'h0000)); // R2=1234
    vecs.push_back(mk(1,2,0,0,8'hFE,1,0,4'h2,4'h3,1,0,0,16'h0000,1,16'h1234,16'hFFFE)); // imm sext
    vecs.push_back(mk(1,2,2,5,8'h00,0,1,4'h3,4'h0,1,0,0,16'h0000,1,16'h1234,16'h1234)); // R5 busy
    vecs.push_back(mk(1,5,0,6,8'h00,0,1,4'h4,4'h1,1,0,0,16'h0000,0,16'h0000,16'h0000)); // RAW stall
    vecs.push_back(mk(1,5,0,6,8'h00,0,1,4'h4,4'h1,1,0,0,16'h0000,0,16'h0000,16'h0000)); // RAW stall
    vecs.push_back(mk(1,5,0,6,8'h00,0,1,4'h4,4'h1,1,1,5,16'h00AA,1,16'h00AA,16'h0000)); // wb bypass
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,4'h0,4'h0,1,1,6,16'h0077,1,16'h0000,16'h0000)); // R6=0077
    vecs.push_back(mk(1,2,6,0,8'h00,0,0,4'h5,4'h2,0,0,0,16'h0000,1,16'h1234,16'h0077)); // backpressure
    vecs.push_back(mk(1,6,2,0,8'h00,0,0,4'h6,4'h7,0,0,0,16'h0000,0,16'h0000,16'h0000));
    vecs.push_back(mk(1,6,2,0,8'h00,0,0,4'h6,4'h7,0,0,0,16'h0000,0,16'h0000,16'h0000));
    vecs.push_back(mk(1,6,2,0,8'h00,0,0,4'h6,4'h7,0,0,0,16'h0000,0,16'h0000,16'h0000));
    vecs.push_back(mk(1,6,2,0,8'h00,0,0,4'h6,4'h7,1,0,0,16'h0000,1,16'h0077,16'h1234)); // release
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,4'h0,4'h0,1,1,0,16'hFFFF,1,16'h0000,16'h0000)); // R0 write
    vecs.push_back(mk(1,0,0,0,8'h00,0,1,4'h7,4'h0,1,0,0,16'h0000,1,16'h0000,16'h0000)); // rd=0
    vecs.push_back(mk(1,0,0,0,8'h00,0,1,4'h8,4'h0,1,0,0,16'h0000,1,16'h0000,16'h0000)); // no stall
    vecs.push_back(mk(1,0,0,1,8'h7F,1,0,4'h9,4'hF,1,0,0,16'h0000,1,16'h0000,16'h007F)); // +imm
    vecs.push_back(mk(1,0,0,1,8'h80,1,0,4'h9,4'h8,1,0,0,16'h0000,1,16'h0000,16'hFF80)); // -imm
    vecs.push_back(mk(1,3,0,3,8'h00,0,1,4'hA,4'h0,1,1,3,16'h0333,1,16'h0333,16'h0000)); // set wins
    vecs.push_back(mk(1,3,0,0,8'h00,0,0,4'hB,4'h0,1,0,0,16'h0000,0,16'h0000,16'h0000)); // R3 busy
    vecs.push_back(mk(1,3,0,0,8'h00,0,0,4'hB,4'h0,1,1,3,16'h0444,1,16'h0444,16'h0000)); // clear
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,4'h0,4'h0,1,1,4,16'h4444,1,16'h0000,16'h0000)); // R4=4444

    foreach (vecs[i]) step(vecs[i]);

    // Reset while the execute register is full and R4 is busy.
    step(mk(1,4,0,4,8'h00,0,1,4'hC,4'h0,0,0,0,16'h0000,1,16'h4444,16'h0000));
    @(posedge clk); #2;
    chk("pre-rst ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    rst_n = 1'b0;
    drive(idle);
    #1;
    chk("mid-rst ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("mid-rst ex_wr_en", {31'd0, bus.ex_wr_en}, 32'd0);
    chk("mid-rst ex_a", {16'd0, bus.ex_a}, 32'd0);
    chk("mid-rst ex_rd", {29'd0, bus.ex_rd}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(1,4,4,4,8'h00,0,1,4'hD,4'h0,1,0,0,16'h0000,1,16'h0000,16'h0000)); // R4 free, reads 0
    step(idle);
    step(idle);
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/operand_issue_stage.md
# operand_issue_stage

Operand-fetch and issue stage directly upstream of the 16-bit ALU. It holds the 8×16 register file and a per-register busy scoreboard, and selects the A/B operands, ALUOp and shamt. These values are registered into an execute-stage pipeline register with a valid/ready handshake. Writeback results return to the same block through the write port.

## Interface
- `DATA_W`, 16, operand/register width
- `REG_N`, 8, number of architectural registers (address width log2 = 3)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage accepts instruction this cycle
- `in_rs`, `in_rt`, `in_rd`  in  3  source A, source B and destination register addresses
- `in_imm`  in  8  immediate, sign-extended to 16
- `in_use_imm`  in  1  B operand = sext(`in_imm`) instead of R[`in_rt`]
- `in_wr_en`  in  1  instruction writes `in_rd`
- `in_aluop`  in  4  ALU operation, passed through unchanged
- `in_shamt`  in  4  shift amount, passed through unchanged
- `ex_valid`  out  1  execute register holds a valid instruction
- `ex_ready`  in  1  ALU/execute stage consumes this cycle
- `ex_a`, `ex_b`  out  16  ALU operands A, B
- `ex_aluop`  out  4  to ALU ALUOp
- `ex_shamt`  out  4  to ALU shamt
- `ex_rd`  out  3  destination register
- `ex_wr_en`  out  1  destination write enable
- `wb_en`  in  1  writeback strobe
- `wb_addr`  in  3  writeback register
- `wb_data`  in  16  writeback value

## Operation
- R0 reads as 0. Writes to R0 are ignored, and R0 is never marked busy.
- Reads are combinational. If `wb_en` is set and `wb_addr` equals the read address (non-zero), the read returns `wb_data` (write-through bypass).
- Scoreboard: one busy bit per register.
  - Set on issue when `in_wr_en` = 1 and `in_rd` ≠ 0.
  - Cleared when `wb_en` = 1 for that address.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard: the instruction stalls if R[`in_rs`] is busy, or if `in_use_imm` = 0 and R[`in_rt`] is busy. A busy bit that is being cleared this cycle does not cause a stall, because the bypass supplies the data.
- Write-after-write: the instruction also stalls if `in_wr_en` = 1 and R[`in_rd`] is busy.
- `in_ready` = ~hazard & (~`ex_valid` | `ex_ready`).
- Issue occurs when `in_valid` & `in_ready`. At issue, the execute register loads A, B, aluop, shamt, rd and wr_en, and `ex_valid` ← 1.
- If `ex_ready` is high and there is no issue, `ex_valid` ← 0.
- While `ex_valid` & ~`ex_ready`, all `ex_*` outputs hold stable.
- Sign extension: B = {{8{imm[7]}}, imm}.

## Timing
- Reset (async, while `rst_n` = 0):
  - all registers R0–R7 = 0x0000 and all busy bits = 0
  - `ex_valid` = 0, `ex_wr_en` = 0
  - `ex_a` = `ex_b` = 0, `ex_aluop` = 0, `ex_shamt` = 0, `ex_rd` = 0
  - `in_ready` = 1 after reset deasserts
- Reset mid-operation discards the in-flight instruction and all scoreboard state.
- Latency is one cycle: an instruction accepted at edge N appears on `ex_*` after edge N.
- Throughput is one instruction per cycle when there are no hazards and `ex_ready` = 1.
- A writeback at edge N updates the register file at edge N. An instruction issued in the same cycle reads the bypassed value.
- `in_ready` depends combinationally on `ex_ready` and the `wb_*` inputs. There is no combinational path from `in_valid` to `in_ready`.

## Structure
- Shared package `cpu16_pkg`: `DATA_W`, `REG_N`, `REG_AW` = 3, `IMM_W` = 8, ALUOp width 4, shamt width 4.
- Sub-module `reg_file_8x16`: two async read ports with bypass, one sync write port, R0 hard-zero, async active-low reset.
- The scoreboard, hazard logic and execute register live in the top module.

## Test plan
- Reset then idle: `ex_valid` = 0, `in_ready` = 1; reading R3 gives 0x0000.
- Write R2 = 0x1234 via wb. Then issue rs = 2, rt = 0, use_imm = 1, imm = 0xFE, aluop = 4'h2 → next cycle `ex_a` = 0x1234, `ex_b` = 0xFFFE, `ex_aluop` = 4'h2.
- Issue a write to rd = 5, then immediately an instruction with rs = 5 → `in_ready` = 0 until `wb_en` with addr 5 and data 0x00AA. In that wb cycle the stalled instruction issues with `ex_a` = 0x00AA.
- Back-to-back issues with `ex_ready` = 0 for 3 cycles → `ex_*` outputs held, `in_ready` = 0; on release, the next instruction issues the following cycle.
- Write R0 = 0xFFFF via wb, then issue rs = 0 with wr_en to rd = 0 → `ex_a` = 0, no busy bit set, and the next instruction does not stall.
- Assert `rst_n` low while `ex_valid` = 1 and R4 is busy → `ex_valid` drops immediately, all busy bits are cleared, and an instruction reading R4 issues without stall after reset.
